wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the register-file write port between the pipeline W stage and a long-latency multiply/divide unit (MDU) result stream. The pipeline W stage has priority; MDU results are buffered in a small pending FIFO and drained on free cycles. A starvation counter forces a pipeline stall so the buffer drains. The block also flags decode-stage reads of registers still pending in the buffer. It sits between the W-stage write-data mux output and the register file write port.

Parameters:
DATA_W, 32, register data width
REG_AW, 5, register address width
DEPTH, 2, pending FIFO entries (power of two, >=2)
STARVE_MAX, 4, consecutive denied cycles before a forced drain (>=1)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_reg_write_W  in  1  W-stage write request
i_write_reg_W  in  REG_AW  W-stage destination
i_write_data_W  in  DATA_W  W-stage write data (output of W-stage select mux)
i_mdu_valid  in  1  MDU result valid
i_mdu_reg  in  REG_AW  MDU destination
i_mdu_data  in  DATA_W  MDU result
o_mdu_ready  out  1  FIFO can accept
i_rs_D  in  REG_AW  decode source A
i_rt_D  in  REG_AW  decode source B
o_hazard_D  out  1  decode source matches a valid pending entry
o_stall  out  1  freeze all pipeline registers including M/W
o_rf_we  out  1  register-file write enable
o_rf_addr  out  REG_AW  register-file write address
o_rf_data  out  DATA_W  register-file write data
o_src  out  1  0 = pipeline, 1 = MDU

Behaviour:
- Clock is i_clk; reset is i_reset, asynchronous and active-high. Reset clears the FIFO (all valid bits 0), the starvation counter and the FSM (state NORMAL). All outputs are 0 during reset except o_mdu_ready, which is 1 once the FIFO is empty.
- The write-port outputs are combinational from the current state, the inputs and the FIFO head. The pipeline path has zero latency.
- MDU handshake: an entry is accepted when i_mdu_valid && o_mdu_ready at a clock edge. o_mdu_ready = !full, registered-free. A push and a pop in the same cycle are allowed when full is 0. Full blocks push even if a pop occurs in the same cycle.
- MDU results with i_mdu_reg == 0 are accepted and discarded; they are not enqueued.
- FSM states and grant rules:
  - NORMAL: if i_reg_write_W, grant the pipeline. Otherwise, if the FIFO is non-empty, pop the head and grant the MDU.
  - FORCE: o_stall = 1 and the FIFO head is granted unconditionally. The pipeline holds its W instruction, which is retried after FORCE exits.
- Starvation counter:
  - Increments in NORMAL when the FIFO is non-empty and the pipeline is granted.
  - Clears on any MDU grant or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, the next state is FORCE.
  - FORCE lasts exactly one cycle (one pop), then returns to NORMAL with the counter cleared.
- o_rf_we = grant && (granted addr != 0). o_rf_addr and o_rf_data hold the granted values; they are 0 when there is no grant.
- Ordering: a pipeline write to register R invalidates every valid FIFO entry targeting R in the same cycle, because the pipeline write is younger. Invalidated entries still occupy their slots. When popped they produce o_rf_we = 0 and do not count as a grant for the counter.
- o_hazard_D = OR over valid entries of (reg == i_rs_D || reg == i_rt_D), excluding register 0. A same-cycle incoming MDU push is not included.
- Reset mid-operation discards buffered results; the MDU must re-issue.
- Pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.

Optional Feature:
WB_ARB_BYPASS_EN:
- Defined: when the FIFO is empty, the state is NORMAL, !i_reg_write_W and i_mdu_valid with a nonzero destination, the MDU data is written the same cycle (o_src = 1) and not enqueued. MDU latency becomes 0.
- Undefined: every MDU result is enqueued first, giving a minimum MDU-to-write latency of 1 cycle.

Decomposition:
- Package wb_arb_pkg:
  - REG_AW/DATA_W defaults
  - SRC_PIPE = 0, SRC_MDU = 1
  - FSM state typedef (NORMAL, FORCE)
  - pending-entry struct {valid, reg, data}
- Sub-module wb_pend_fifo: holds storage, pointers and full/empty, plus per-entry invalidate-by-address and an address-match output. The arbiter FSM and counter stay in wb_port_arbiter.

Test Plan:
- Reset, then MDU push reg 5 = 0xDEAD with pipeline idle -> next cycle o_rf_we = 1, addr 5, data 0xDEAD, o_src = 1. With the bypass macro, the write occurs in the same cycle.
- Pipeline writes every cycle (reg 3 = 0x11), one MDU entry for reg 7 buffered -> o_stall pulses 1 exactly STARVE_MAX = 4 cycles later. That cycle writes reg 7, then pipeline reg 3 retries.
- Push reg 9 and reg 10 while the pipeline is busy -> o_mdu_ready = 0. A third i_mdu_valid is held until a pop, and no data is lost.
- FIFO holds reg 8 = 0xAAAA, pipeline writes reg 8 = 0xBBBB -> entry killed. A later free cycle gives o_rf_we = 0, and the final reg 8 is 0xBBBB.
- FIFO holds reg 12; i_rs_D = 12 -> o_hazard_D = 1. i_rt_D = 0 with an MDU entry for reg 0 -> o_hazard_D = 0 and nothing enqueued.
- Assert i_reset asynchronously with 2 entries pending and o_stall high -> all outputs 0 immediately; after release o_mdu_ready = 1 and no writes occur.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types for the register-file write-port arbiter.
// Holds default widths, source codes, FSM states and the pending-entry shape.
package wb_arb_pkg;

  localparam int DATA_W_D = 32;
  localparam int REG_AW_D = 5;

  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_MDU  = 1'b1;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [REG_AW_D-1:0] rd;
    logic [DATA_W_D-1:0] data;
  } pend_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: W-stage, MDU, decode and register-file write signals.
// master drives W/MDU/decode inputs; slave is the arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  logic              i_reg_write_W;
  logic [REG_AW-1:0] i_write_reg_W;
  logic [DATA_W-1:0] i_write_data_W;
  logic              i_mdu_valid;
  logic [REG_AW-1:0] i_mdu_reg;
  logic [DATA_W-1:0] i_mdu_data;
  logic              o_mdu_ready;
  logic [REG_AW-1:0] i_rs_D;
  logic [REG_AW-1:0] i_rt_D;
  logic              o_hazard_D;
  logic              o_stall;
  logic              o_rf_we;
  logic [REG_AW-1:0] o_rf_addr;
  logic [DATA_W-1:0] o_rf_data;
  logic              o_src;

  modport slave (
    input  i_reg_write_W, i_write_reg_W, i_write_data_W,
    input  i_mdu_valid, i_mdu_reg, i_mdu_data,
    input  i_rs_D, i_rt_D,
    output o_mdu_ready, o_hazard_D, o_stall,
    output o_rf_we, o_rf_addr, o_rf_data, o_src
  );

  modport master (
    output i_reg_write_W, i_write_reg_W, i_write_data_W,
    output i_mdu_valid, i_mdu_reg, i_mdu_data,
    output i_rs_D, i_rt_D,
    input  o_mdu_ready, o_hazard_D, o_stall,
    input  o_rf_we, o_rf_addr, o_rf_data, o_src
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// wb_pend_fifo: pending MDU results with invalidate-by-address and match.
// Ports: push/pop, head entry, full/empty, inv_en/inv_reg, rs/rt -> match.
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_AW = REG_AW_D,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              inv_en,
  input  logic [REG_AW-1:0] inv_reg,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              full,
  output logic              empty,
  output logic              head_valid,
  output logic [REG_AW-1:0] head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic              match
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;

  assign wr_idx = wr_ptr[PW-1:0];
  assign rd_idx = rd_ptr[PW-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW])
              && (wr_idx == rd_idx);

  assign head_valid = mem[rd_idx].valid;
  assign head_reg   = mem[rd_idx].rd;
  assign head_data  = mem[rd_idx].data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // A younger pipeline write kills older buffered results;
      // the slot stays occupied until popped.
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && mem[i].valid
            && mem[i].rd == inv_reg) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_idx].valid <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Same-cycle push is newer than the W write: keep it valid.
      if (push) begin
        mem[wr_idx] <= '{1'b1, push_reg, push_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid && mem[i].rd != '0
          && (mem[i].rd == rs || mem[i].rd == rt)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between W stage and MDU.
// Ports: i_clk, i_reset, bus (slave). Optional macro: WB_ARB_BYPASS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int REG_AW     = REG_AW_D,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              full, empty;
  logic              head_valid;
  logic [REG_AW-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic              match;
  logic              push, pop, byp;
  logic              pipe_gnt, mdu_gnt, stall;
  logic [REG_AW-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  wb_pend_fifo #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst        (i_reset),
    .push       (push),
    .push_reg   (bus.i_mdu_reg),
    .push_data  (bus.i_mdu_data),
    .pop        (pop),
    .inv_en     (pipe_gnt),
    .inv_reg    (bus.i_write_reg_W),
    .rs         (bus.i_rs_D),
    .rt         (bus.i_rt_D),
    .full       (full),
    .empty      (empty),
    .head_valid (head_valid),
    .head_reg   (head_reg),
    .head_data  (head_data),
    .match      (match)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    pipe_gnt = 1'b0;
    mdu_gnt  = 1'b0;
    pop      = 1'b0;
    byp      = 1'b0;
    stall    = 1'b0;
    g_addr   = '0;
    g_data   = '0;
    state_n  = state;
    cnt_n    = cnt;
    if (!i_reset) begin
      unique case (state)
        NORMAL: begin
          if (bus.i_reg_write_W) begin
            pipe_gnt = 1'b1;
            g_addr   = bus.i_write_reg_W;
            g_data   = bus.i_write_data_W;
          end else if (!empty) begin
            pop     = 1'b1;
            mdu_gnt = head_valid;
          end
`ifdef WB_ARB_BYPASS_EN
          else if (bus.i_mdu_valid
                   && bus.i_mdu_reg != '0) begin
            byp     = 1'b1;
            mdu_gnt = 1'b1;
            g_addr  = bus.i_mdu_reg;
            g_data  = bus.i_mdu_data;
          end
`endif
        end
        FORCE: begin
          stall   = 1'b1;
          pop     = !empty;
          mdu_gnt = !empty && head_valid;
        end
      endcase
      // Killed entries popped here leave g_addr/g_data at 0.
      if (pop && head_valid) begin
        g_addr = head_reg;
        g_data = head_data;
      end
      if (state == FORCE) begin
        state_n = NORMAL;
        cnt_n   = '0;
      end else begin
        if (empty || mdu_gnt) begin
          cnt_n = '0;
        end else if (pipe_gnt) begin
          cnt_n = cnt + 1'b1;
        end
        if (cnt_n == CW'(STARVE_MAX)) begin
          state_n = FORCE;
        end
      end
    end
  end

  // reg 0 results are accepted and dropped.
  assign push = !i_reset && bus.i_mdu_valid && !full
             && bus.i_mdu_reg != '0 && !byp;

  assign bus.o_mdu_ready = !full;
  assign bus.o_hazard_D  = match && !i_reset;
  assign bus.o_stall     = stall;
  assign bus.o_rf_we     = (pipe_gnt || mdu_gnt)
                        && g_addr != '0;
  assign bus.o_rf_addr   = g_addr;
  assign bus.o_rf_data   = g_data;
  assign bus.o_src       = mdu_gnt ? SRC_MDU : SRC_PIPE;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of the RF write-port arbiter.
// Covers reset, MDU drain, starvation force, full FIFO, kill, hazard, reset.
module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [31:0] shadow [32];

  wb_port_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();

  wb_port_arbiter #(
    .DATA_W     (32),
    .REG_AW     (5),
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_rf_we) shadow[bus.o_rf_addr] <= bus.o_rf_data;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_reg_write_W  = 1'b0;
    bus.i_write_reg_W  = '0;
    bus.i_write_data_W = '0;
    bus.i_mdu_valid    = 1'b0;
    bus.i_mdu_reg      = '0;
    bus.i_mdu_data     = '0;
    bus.i_rs_D         = '0;
    bus.i_rt_D         = '0;
  endtask

  task automatic wr_w(input logic [4:0] r,
                      input logic [31:0] d);
    bus.i_reg_write_W  = 1'b1;
    bus.i_write_reg_W  = r;
    bus.i_write_data_W = d;
  endtask

  task automatic mdu(input logic [4:0] r,
                     input logic [31:0] d);
    bus.i_mdu_valid = 1'b1;
    bus.i_mdu_reg   = r;
    bus.i_mdu_data  = d;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    wr_w(5'd3, 32'h11);
    #2;
    chk("rst_we", bus.o_rf_we, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_ready", bus.o_mdu_ready, 1);
    chk("rst_src", bus.o_src, 0);
    chk("rst_addr", bus.o_rf_addr, 0);
    chk("rst_haz", bus.o_hazard_D, 0);
    tick();
    tick();
    rst = 1'b0;
    idle();

    // MDU result with idle pipeline
    mdu(5'd5, 32'hDEAD);
    #1;
`ifdef WB_ARB_BYPASS_EN
    chk("t1_byp_we", bus.o_rf_we, 1);
    chk("t1_byp_addr", bus.o_rf_addr, 5);
    chk("t1_byp_data", bus.o_rf_data, 32'hDEAD);
    chk("t1_byp_src", bus.o_src, 1);
    tick();
    bus.i_mdu_valid = 1'b0;
    #1;
    chk("t1_byp_next_we", bus.o_rf_we, 0);
`else
    chk("t1_same_we", bus.o_rf_we, 0);
    tick();
    bus.i_mdu_valid = 1'b0;
    #1;
    chk("t1_we", bus.o_rf_we, 1);
    chk("t1_addr", bus.o_rf_addr, 5);
    chk("t1_data", bus.o_rf_data, 32'hDEAD);
    chk("t1_src", bus.o_src, 1);
`endif
    tick();
    chk("t1_drained", bus.o_rf_we, 0);

    // starvation: pipeline writes every cycle
    wr_w(5'd3, 32'h11);
    mdu(5'd7, 32'h77);
    #1;
    chk("t2_pipe_we", bus.o_rf_we, 1);
    chk("t2_pipe_addr", bus.o_rf_addr, 3);
    chk("t2_pipe_src", bus.o_src, 0);
    tick();
    bus.i_mdu_valid = 1'b0;
    #1;
    chk("t2_stall_c1", bus.o_stall, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_wait", bus.o_stall, 0);
      chk("t2_wait_addr", bus.o_rf_addr, 3);
    end
    tick();
    chk("t2_force_stall", bus.o_stall, 1);
    chk("t2_force_we", bus.o_rf_we, 1);
    chk("t2_force_addr", bus.o_rf_addr, 7);
    chk("t2_force_data", bus.o_rf_data, 32'h77);
    chk("t2_force_src", bus.o_src, 1);
    tick();
    chk("t2_retry_stall", bus.o_stall, 0);
    chk("t2_retry_addr", bus.o_rf_addr, 3);
    chk("t2_retry_src", bus.o_src, 0);
    chk("t2_retry_we", bus.o_rf_we, 1);
    chk("t2_shadow7", shadow[7], 32'h77);

    // fill FIFO while pipeline busy
    mdu(5'd9, 32'h9);
    #1;
    chk("t3_rdy0", bus.o_mdu_ready, 1);
    tick();
    mdu(5'd10, 32'hA);
    #1;
    chk("t3_rdy1", bus.o_mdu_ready, 1);
    tick();
    mdu(5'd11, 32'hB);
    #1;
    chk("t3_full", bus.o_mdu_ready, 0);
    tick();
    bus.i_reg_write_W = 1'b0;
    #1;
    chk("t3_pop9_addr", bus.o_rf_addr, 9);
    chk("t3_pop9_data", bus.o_rf_data, 32'h9);
    chk("t3_pop9_rdy", bus.o_mdu_ready, 0);
    tick();
    chk("t3_pop10_addr", bus.o_rf_addr, 10);
    chk("t3_pop10_data", bus.o_rf_data, 32'hA);
    chk("t3_pop10_rdy", bus.o_mdu_ready, 1);
    tick();
    bus.i_mdu_valid = 1'b0;
    #1;
    chk("t3_pop11_we", bus.o_rf_we, 1);
    chk("t3_pop11_addr", bus.o_rf_addr, 11);
    chk("t3_pop11_data", bus.o_rf_data, 32'hB);
    tick();
    chk("t3_empty_we", bus.o_rf_we, 0);

    // younger pipeline write kills buffered entry
    wr_w(5'd3, 32'h11);
    mdu(5'd8, 32'hAAAA);
    #1;
    tick();
    bus.i_mdu_valid = 1'b0;
    wr_w(5'd8, 32'hBBBB);
    bus.i_rs_D = 5'd8;
    #1;
    chk("t4_w_addr", bus.o_rf_addr, 8);
    chk("t4_w_data", bus.o_rf_data, 32'hBBBB);
    chk("t4_haz_pre", bus.o_hazard_D, 1);
    tick();
    bus.i_reg_write_W = 1'b0;
    #1;
    chk("t4_kill_we", bus.o_rf_we, 0);
    chk("t4_kill_addr", bus.o_rf_addr, 0);
    chk("t4_kill_src", bus.o_src, 0);
    chk("t4_haz_post", bus.o_hazard_D, 0);
    tick();
    chk("t4_after_we", bus.o_rf_we, 0);
    chk("t4_shadow8", shadow[8], 32'hBBBB);

    // decode hazard
    wr_w(5'd3, 32'h11);
    mdu(5'd12, 32'hC);
    bus.i_rs_D = 5'd12;
    bus.i_rt_D = 5'd0;
    #1;
    chk("t5_haz_push", bus.o_hazard_D, 0);
    tick();
    mdu(5'd0, 32'hFF);
    #1;
    chk("t5_haz_rs", bus.o_hazard_D, 1);
    bus.i_rs_D = 5'd0;
    #1;
    chk("t5_haz_r0", bus.o_hazard_D, 0);
    tick();
    bus.i_mdu_valid   = 1'b0;
    bus.i_reg_write_W = 1'b0;
    #1;
    chk("t5_r0_drop", bus.o_mdu_ready, 1);
    chk("t5_pop12", bus.o_rf_addr, 12);
    tick();
    chk("t5_after_we", bus.o_rf_we, 0);

    // async reset during FORCE with FIFO full
    wr_w(5'd3, 32'h11);
    mdu(5'd20, 32'h20);
    #1;
    tick();
    mdu(5'd21, 32'h21);
    #1;
    chk("t6_rdy", bus.o_mdu_ready, 1);
    tick();
    bus.i_mdu_valid = 1'b0;
    #1;
    chk("t6_full", bus.o_mdu_ready, 0);
    tick();
    tick();
    tick();
    chk("t6_stall", bus.o_stall, 1);
    chk("t6_force_addr", bus.o_rf_addr, 20);
    #1;
    rst = 1'b1;
    bus.i_rs_D = 5'd20;
    #1;
    chk("t6_rst_stall", bus.o_stall, 0);
    chk("t6_rst_we", bus.o_rf_we, 0);
    chk("t6_rst_addr", bus.o_rf_addr, 0);
    chk("t6_rst_data", bus.o_rf_data, 0);
    chk("t6_rst_src", bus.o_src, 0);
    chk("t6_rst_haz", bus.o_hazard_D, 0);
    chk("t6_rst_rdy", bus.o_mdu_ready, 1);
    #2;
    rst = 1'b0;
    idle();
    tick();
    chk("t6_post_we", bus.o_rf_we, 0);
    chk("t6_post_rdy", bus.o_mdu_ready, 1);
    tick();
    chk("t6_post_we2", bus.o_rf_we, 0);
    chk("t6_post_stall", bus.o_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
